// File: rtl/adder_err_eval_pkg.sv
// Shared types and helpers for the approximate-adder error evaluator.
//   state_e   : run-control FSM states
//   *_DEF     : default parameter values for the block
//   abs_diff  : unsigned magnitude of the difference of two operands
package adder_err_eval_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned CNT_W_DEF = 32;
  localparam int unsigned ACC_W_DEF = 48;

  // Working width for abs_diff; callers narrow the result to their own width.
  localparam int unsigned ED_MAX_W  = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic logic [ED_MAX_W-1:0] abs_diff(input logic [ED_MAX_W-1:0] x,
                                                   input logic [ED_MAX_W-1:0] y);
    return (x >= y) ? (x - y) : (y - x);
  endfunction

endpackage

// File: rtl/adder_err_eval_if.sv
// Sample stream into the error evaluator.
//   in_valid/in_ready : transfer handshake (transfer when both high)
//   a, b              : operands fed to the adder under test
//   approx_sum        : WIDTH+1-bit result of the adder under test
// master drives samples, slave accepts them.
interface adder_err_eval_if
  import adder_err_eval_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0]   approx_sum;

  modport master (output in_valid, a, b, approx_sum, input in_ready);
  modport slave  (input in_valid, a, b, approx_sum, output in_ready);

endinterface

// File: rtl/adder_err_eval_ed_calc.sv
// Two-stage error-distance pipeline.
//   S1: registers the exact WIDTH+1-bit sum a+b and the approximate result.
//   S2: registers ed = |exact - approx| and nz = (ed != 0).
// Ports: clk, rst (async active-high), in_fire (sample accepted this cycle),
//        a, b, approx_sum (sample), s1_valid/s2_valid (stage occupancy),
//        ed, nz (S2 outputs, meaningful while s2_valid).
module adder_err_eval_ed_calc
  import adder_err_eval_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_fire,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH:0]   approx_sum,
  output logic             s1_valid,
  output logic             s2_valid,
  output logic [WIDTH:0]   ed,
  output logic             nz
);

  logic           s1_v_q, s1_v_d;
  logic           s2_v_q, s2_v_d;
  logic [WIDTH:0] exact_q, exact_d;
  logic [WIDTH:0] approx_q, approx_d;
  logic [WIDTH:0] ed_q, ed_d;
  logic           nz_q, nz_d;

  always_comb begin
    s1_v_d   = in_fire;
    exact_d  = exact_q;
    approx_d = approx_q;
    if (in_fire) begin
      exact_d  = {1'b0, a} + {1'b0, b};
      approx_d = approx_sum;
    end

    s2_v_d = s1_v_q;
    ed_d   = ed_q;
    nz_d   = nz_q;
    if (s1_v_q) begin
      ed_d = (WIDTH+1)'(abs_diff(ED_MAX_W'(exact_q), ED_MAX_W'(approx_q)));
      nz_d = (ed_d != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q   <= 1'b0;
      s2_v_q   <= 1'b0;
      exact_q  <= '0;
      approx_q <= '0;
      ed_q     <= '0;
      nz_q     <= 1'b0;
    end else begin
      s1_v_q   <= s1_v_d;
      s2_v_q   <= s2_v_d;
      exact_q  <= exact_d;
      approx_q <= approx_d;
      ed_q     <= ed_d;
      nz_q     <= nz_d;
    end
  end

  assign s1_valid = s1_v_q;
  assign s2_valid = s2_v_q;
  assign ed       = ed_q;
  assign nz       = nz_q;

endmodule

// File: rtl/adder_err_eval.sv
// Error-evaluation engine for approximate adders.
// Accepts num_samples samples, measures each error distance through the
// ed_calc pipeline and accumulates: count of erroneous samples, maximum
// error distance and saturating sum of error distances.
// Ports: clk, rst (async active-high), start, num_samples, s_if (sample
//        stream, slave side), busy (RUN/DRAIN), done (one-cycle pulse),
//        err_count, max_ed, sum_ed, sample_cnt (registered statistics).
module adder_err_eval
  import adder_err_eval_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned ACC_W = ACC_W_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [CNT_W-1:0]   num_samples,
  adder_err_eval_if.slave    s_if,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   err_count,
  output logic [WIDTH:0]     max_ed,
  output logic [ACC_W-1:0]   sum_ed,
  output logic [CNT_W-1:0]   sample_cnt
);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   target_q, target_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [WIDTH:0]     max_ed_q, max_ed_d;
  logic [ACC_W-1:0]   sum_ed_q, sum_ed_d;
  logic [CNT_W-1:0]   sample_cnt_q, sample_cnt_d;

  logic               fire;
  logic               s1_valid, s2_valid;
  logic [WIDTH:0]     s2_ed;
  logic               s2_nz;
  logic [ACC_W:0]     sum_wide;

  assign fire = s_if.in_valid && in_ready_q;

  adder_err_eval_ed_calc #(.WIDTH(WIDTH)) u_ed_calc (
    .clk        (clk),
    .rst        (rst),
    .in_fire    (fire),
    .a          (s_if.a),
    .b          (s_if.b),
    .approx_sum (s_if.approx_sum),
    .s1_valid   (s1_valid),
    .s2_valid   (s2_valid),
    .ed         (s2_ed),
    .nz         (s2_nz)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    done_d       = 1'b0;
    err_count_d  = err_count_q;
    max_ed_d     = max_ed_q;
    sum_ed_d     = sum_ed_q;
    sample_cnt_d = sample_cnt_q;
    sum_wide     = {1'b0, sum_ed_q} + (ACC_W+1)'(s2_ed);

    if (s2_valid) begin
      if (s2_nz && (err_count_q != '1)) err_count_d = err_count_q + 1'b1;
      if (s2_ed > max_ed_q) max_ed_d = s2_ed;
      sum_ed_d = sum_wide[ACC_W] ? '1 : sum_wide[ACC_W-1:0];
    end

    // The pipeline is always empty in IDLE/DONE, so clearing the statistics
    // on start never races with an accumulation.
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          target_d     = num_samples;
          err_count_d  = '0;
          max_ed_d     = '0;
          sum_ed_d     = '0;
          sample_cnt_d = '0;
          if (num_samples == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (fire) begin
          sample_cnt_d = sample_cnt_q + 1'b1;
          if (sample_cnt_d == target_q) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (!s1_valid && !s2_valid) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // Ready is registered from next-state values so it is already correct
    // in the first RUN cycle and drops right after the final transfer.
    in_ready_d = (state_d == RUN) && (sample_cnt_d < target_d);
    busy_d     = (state_d == RUN) || (state_d == DRAIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      target_q     <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_count_q  <= '0;
      max_ed_q     <= '0;
      sum_ed_q     <= '0;
      sample_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_count_q  <= err_count_d;
      max_ed_q     <= max_ed_d;
      sum_ed_q     <= sum_ed_d;
      sample_cnt_q <= sample_cnt_d;
    end
  end

  assign s_if.in_ready = in_ready_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err_count     = err_count_q;
  assign max_ed        = max_ed_q;
  assign sum_ed        = sum_ed_q;
  assign sample_cnt    = sample_cnt_q;

endmodule

// File: doc/adder_err_eval.md
Name: adder_err_eval

Overview:
Sequential error-evaluation engine on the consumer side of the approximate-adder netlists. Each accepted sample carries an operand pair and the (WIDTH+1)-bit result of the adder under test. The block recomputes the exact sum, forms the error distance and accumulates run statistics over a programmed number of samples. It reports the results with a one-cycle done pulse.

Parameters:
WIDTH, 16, operand width; the adder result is WIDTH+1 bits, carry in the MSB.
CNT_W, 32, width of the sample target and all counters.
ACC_W, 48, width of the error-distance accumulator.

Ports:
clk  in  1  system clock.
rst  in  1  reset (one clock; reset is asynchronous and active-high).
start  in  1  begins a run; sampled only in IDLE or DONE.
num_samples  in  CNT_W  run length; captured on an accepted start.
in_valid  in  1  sample valid.
in_ready  out  1  sample accept; a transfer occurs when in_valid and in_ready are both 1.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
approx_sum  in  WIDTH+1  result of the adder under test for (a,b).
busy  out  1  high in RUN and DRAIN.
done  out  1  one-cycle pulse at end of run.
err_count  out  CNT_W  number of samples with a nonzero error distance.
max_ed  out  WIDTH+1  largest error distance in the run.
sum_ed  out  ACC_W  sum of error distances, saturating.
sample_cnt  out  CNT_W  samples accepted in the current or last run.

Behaviour:
- Reset: state=IDLE; in_ready, busy, done = 0; err_count, max_ed, sum_ed, sample_cnt = 0; pipeline valids = 0. Asynchronous assert, synchronous deassert at the clk edge. Reset in the middle of a run aborts it and produces no done.
- States:
  - IDLE -> RUN on start; captures num_samples and clears all statistics.
  - If num_samples==0: IDLE -> DONE directly. done pulses the next cycle and all stats stay 0.
  - RUN: in_ready = (sample_cnt < target). Each transfer increments sample_cnt. On the transfer that makes sample_cnt == target -> DRAIN.
  - DRAIN: in_ready=0. Waits until both pipeline stages are empty -> DONE.
  - DONE: done=1 for exactly one cycle. The state then holds in DONE with done=0 and stats frozen. start in DONE behaves as in IDLE.
  - start in RUN or DRAIN is ignored.
- Pipeline:
  - S1 registers exact = a+b (WIDTH+1 bits, no truncation) and approx_sum.
  - S2 registers ed = |exact - approx| (WIDTH+1 bits, unsigned magnitude) and nz = (ed != 0).
  - Accumulate: err_count += nz; max_ed = max(max_ed, ed); sum_ed += zero-extended ed.
  - sum_ed saturates at all-ones and never wraps. err_count saturates likewise.
- Latency:
  - Stats reflect a sample 3 cycles after its transfer.
  - done rises 4 cycles after the final transfer (S1, S2, accumulate, DONE).
- The handshake is back-pressure free inside the block. in_valid low inserts bubbles and has no other effect.
- Outputs are registered. Stats are readable at all times and are final when done pulses.

Decomposition:
- Package adder_err_eval_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default WIDTH/CNT_W/ACC_W localparams;
  - a function returning the absolute difference.
- One natural sub-module: ed_calc (S1+S2 pipeline: exact sum, error distance, valid propagation).
- FSM, counters and accumulators stay in the top.

Test Plan:
- num_samples=4; samples (0xFFFF,0x0001,0x10000), (0x1234,0x0001,0x01235), (0,0,0), (0x8000,0x8000,0x10000) -> err_count=0, max_ed=0, sum_ed=0, done 4 cycles after 4th transfer.
- num_samples=3; (0xFFFF,0x0001,0x00000) ed=65536, (5,3,6) ed=2, (5,3,0xA) ed=2 -> err_count=3, max_ed=0x10000, sum_ed=65540.
- num_samples=0 with start -> done pulses the next cycle, busy never high, stats 0.
- num_samples=5 with in_valid toggling every other cycle plus a start mid-run -> start ignored, exactly 5 transfers, in_ready drops after the 5th, sample_cnt=5.
- Reset asserted mid-RUN after 2 samples -> all outputs 0 immediately, no done. A new run of 1 sample (3,4,7) gives err_count=0 and sample_cnt=1.
- ACC_W=17 build, num_samples=3, each ed=0x10000 -> sum_ed saturates at 0x1FFFF, max_ed=0x10000, err_count=3.
